spram_scale_arbiter: RTL
========================

// Module: spram_scale_arbiter
// PURPOSE
//  Controller that shares one single-port scale SRAM (spram_wrapper_scale instance) between a write
//  requester (DMA scale loader) and a read requester (compute engine). One RAM op per cycle,
//  round-robin arbitration, read-data valid tracking, and a zero-fill INIT sweep of the whole array.
//  Sits between the DMA/compute side and the RAM wrapper; mem_* ports connect straight to the wrapper.
// PARAMETERS
//  DW      16  data bit-width per word (matches RAM DW)
//  AW      4   address bit-width (matches RAM AW)
//  DEPTH   16  number of words; need not be a power of 2 (e.g. 832)
//  RD_LAT  1   RAM read latency in cycles (matches RAM N_DELAY)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  init_req   in   1       pulse: start zero-fill of addresses 0..DEPTH-1
//  init_done  out  1       1-cycle pulse when zero-fill completes
//  busy       out  1       1 while in INIT or while any read is in flight
//  wr_valid   in   1       write request
//  wr_addr    in   AW      write address
//  wr_data    in   DW      write data
//  wr_ready   out  1       write accepted when wr_valid & wr_ready at a rising edge
//  rd_valid   in   1       read request
//  rd_addr    in   AW      read address
//  rd_ready   out  1       read accepted when rd_valid & rd_ready at a rising edge
//  rd_rvalid  out  1       rd_rdata valid this cycle (no backpressure)
//  rd_rdata   out  DW      read data, = mem_rdata
//  mem_cs     out  1       RAM chip select (registered)
//  mem_we     out  1       RAM write enable (registered)
//  mem_addr   out  AW      RAM address (registered)
//  mem_wdata  out  DW      RAM write data (registered)
//  mem_rdata  in   DW      RAM read-out data
// BEHAVIOUR
//  - Reset: state=RUN, init counter=0, last_gnt=WRITE (read wins first tie), read-valid pipe=0;
//    all outputs 0.
//  - States: RUN (arbitrate requesters), INIT (zero-fill). RUN->INIT when init_req=1 at an edge;
//    INIT->RUN after the write to DEPTH-1 issues. init_req in INIT is ignored.
//  - Ready generation (combinational, from state/last_gnt/valids; independent of init_req):
//    INIT: wr_ready=rd_ready=0. RUN, one valid only: that side ready=1.
//    RUN, both valid: grant side != last_gnt. last_gnt updates only on an accepted handshake.
//  - Accepted op registered into mem_*: mem_cs=1 in the following cycle; mem_we=1 for writes,
//    0 for reads. No accepted op -> mem_cs=0, mem_we=0. mem_addr/mem_wdata hold their last values.
//  - Read latency: handshake in cycle c -> mem_cs in c+1 -> rd_rvalid=1 in cycle c+1+RD_LAT.
//    Implemented as an RD_LAT+1 deep valid shift register advancing every cycle; back-to-back
//    reads yield back-to-back rd_rvalid.
//  - INIT: counter runs 0..DEPTH-1, one write of zeros per cycle: mem_cs=mem_we=1,
//    mem_addr=count, mem_wdata=0. Count width AW; terminal value DEPTH-1 (non-pow2 safe; no wrap).
//    init_done pulses in the cycle after the last INIT write is on mem_*; counter returns to 0.
//  - init_req and a handshake in the same cycle: the handshake completes and its op issues first;
//    INIT writes start the cycle after. Reads issued before INIT still return rd_rvalid on schedule.
//  - busy = (state==INIT) | (any bit of the valid pipe set).
//  - Async reset mid-INIT or with reads in flight: aborts immediately; no rd_rvalid or init_done
//    follows.
// TESTING (DW=16, AW=4, DEPTH=16, RD_LAT=1, behavioural RAM model)
//  1 wr addr 5 data 0x1234, then rd addr 5 in cycle c -> rd_rvalid=1 in c+2, rd_rdata=0x1234.
//  2 wr_valid and rd_valid held high 8 cycles -> grants R,W,R,W,...; mem_cs=1 every cycle;
//    4 rd_rvalid pulses.
//  3 fill all 16 with 0xFFFF, pulse init_req -> 16 cycles mem_we=1, addr 0..15, data 0, readies
//    low; init_done once; reads then return 0.
//  4 init_req in the same cycle as a wr handshake (addr 3, 0xABCD) -> the write issues first,
//    INIT follows; read addr 3 -> 0.
//  5 assert rst at INIT count 7 -> all outputs 0 at once; state RUN; no init_done;
//    next init_req restarts at 0.
//  6 DEPTH=832, AW=10 -> INIT addresses 0..831, exactly 832 writes, init_done once,
//    then RUN.

Source files
------------

// File: rtl/spram_scale_arbiter.sv
// Shares one single-port scale SRAM between a DMA write requester and a
// compute read requester. One RAM op per cycle, round-robin arbitration,
// read-valid tracking, and a zero-fill sweep of the whole array.
module spram_scale_arbiter #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req,
    output logic          init_done,
    output logic          busy,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_rvalid,
    output logic [DW-1:0] rd_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {ST_RUN, ST_INIT} state_t;
    typedef enum logic {GNT_WR, GNT_RD} gnt_t;

    typedef struct packed {
        logic          cs;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_op_t;

    // Terminal sweep address; compared explicitly so DEPTH need not be a power of 2.
    localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);

    state_t        state;
    gnt_t          last_gnt;
    logic [AW-1:0] init_cnt;
    logic          init_last;   // last sweep write was registered this edge
    logic [RD_LAT:0] vld_pipe;
    mem_op_t       op_q;
    logic          wr_hs, rd_hs;

    // Round-robin readies: on contention the side that did not win last goes.
    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        if (state == ST_RUN) begin
            if (wr_valid && rd_valid) begin
                rd_ready = (last_gnt == GNT_WR);
                wr_ready = (last_gnt == GNT_RD);
            end else begin
                wr_ready = wr_valid;
                rd_ready = rd_valid;
            end
        end
    end

    assign wr_hs = wr_valid & wr_ready;
    assign rd_hs = rd_valid & rd_ready;

    // State machine, RAM op register, sweep counter and read-valid pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            last_gnt  <= GNT_WR;
            init_cnt  <= '0;
            init_last <= 1'b0;
            init_done <= 1'b0;
            vld_pipe  <= '0;
            op_q      <= '0;
        end else begin
            vld_pipe[0] <= rd_hs;
            for (int i = 1; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            init_done <= init_last;
            init_last <= 1'b0;
            op_q.cs   <= 1'b0;
            op_q.we   <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (wr_hs) begin
                        op_q     <= '{cs: 1'b1, we: 1'b1, addr: wr_addr, wdata: wr_data};
                        last_gnt <= GNT_WR;
                    end else if (rd_hs) begin
                        op_q.cs   <= 1'b1;
                        op_q.addr <= rd_addr;
                        last_gnt  <= GNT_RD;
                    end
                    // A handshake in the same cycle is issued above; sweep starts next cycle.
                    if (init_req) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end
                end
                ST_INIT: begin
                    op_q <= '{cs: 1'b1, we: 1'b1, addr: init_cnt, wdata: '0};
                    if (init_cnt == INIT_LAST) begin
                        state     <= ST_RUN;
                        init_cnt  <= '0;
                        init_last <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + AW'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign mem_cs    = op_q.cs;
    assign mem_we    = op_q.we;
    assign mem_addr  = op_q.addr;
    assign mem_wdata = op_q.wdata;
    assign rd_rvalid = vld_pipe[RD_LAT];
    assign rd_rdata  = mem_rdata;
    assign busy      = (state == ST_INIT) | (|vld_pipe);

endmodule
